// File: rtl/fft_fp8_pkg.sv
// Shared E4M3 constants, FSM state type and the quantized W_64^k twiddle table.
// Combinational helpers only; no latency and no flow control here.
// Backpressure: not applicable (package).
package fft_fp8_pkg;

  localparam logic [7:0] FP8_ONE  = 8'h38;
  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam int         FP8_BIAS = 7;
  localparam logic [7:0] FP8_SIGN = 8'h80;
  localparam int         N_MAX    = 64;

  typedef enum logic {
    TW_IDLE = 1'b0,
    TW_RUN  = 1'b1
  } tw_state_e;

  // {re, im} = E4M3 of cos(2*pi*k/64), -sin(2*pi*k/64), round-to-nearest-even
  localparam logic [15:0] W64_TABLE [32] = '{
    {FP8_ONE, FP8_ZERO}, 16'h389D, 16'h38A4, 16'h37A9,
    16'h37AC, 16'h36AF, 16'h35B1, 16'h34B2,
    16'h33B3, 16'h32B4, 16'h31B5, 16'h2FB6,
    16'h2CB7, 16'h29B7, 16'h24B8, 16'h1DB8,
    16'h00B8, 16'h9DB8, 16'hA4B8, 16'hA9B7,
    16'hACB7, 16'hAFB6, 16'hB1B5, 16'hB2B4,
    16'hB3B3, 16'hB4B2, 16'hB5B1, 16'hB6AF,
    16'hB7AC, 16'hB7A9, 16'hB8A4, 16'hB89D
  };

  // Radix-2 DIT exponent k = (j mod 2^s) << (log2n-1-s), rescaled onto the N_MAX table.
  function automatic logic [4:0] tw_rom_addr(input logic [2:0] s, input logic [4:0] j,
                                             input int log2n);
    logic [5:0] k;
    k = ({1'b0, j} & 6'((1 << s) - 1)) << (log2n - 1 - int'(s));
    return 5'(k << ($clog2(N_MAX) - log2n));
  endfunction

endpackage

// File: rtl/fp8_twiddle_rom.sv
// Twiddle lookup into the shared W_64^k table.
// Latency 1 cycle (registered output); en=0 holds the last word so a stalled beat stays put.
module fp8_twiddle_rom
  import fft_fp8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] addr,
  output logic [7:0] tw_re,
  output logic [7:0] tw_im
);

  logic [15:0] rd_d, rd_q;

  always_comb begin
    rd_d = rd_q;
    if (en) rd_d = W64_TABLE[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign tw_re = rd_q[15:8];
  assign tw_im = rd_q[7:0];

endmodule

// File: rtl/fp8_twiddle_gen.sv
// FFT twiddle sequencer: emits log2(N)*N/2 E4M3 beats in radix-2 DIT order; FP8_TWIDDLE_CONJ_EN adds 'inverse'.
// Latency: first beat the cycle after start; one beat per cycle while tw_ready is high.
// Backpressure: tw_ready low freezes every tw_* output until the beat is accepted.
module fp8_twiddle_gen
  import fft_fp8_pkg::*;
#(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef FP8_TWIDDLE_CONJ_EN
  input  logic       inverse,
`endif
  output logic       busy,
  output logic       done,
  output logic       tw_valid,
  input  logic       tw_ready,
  output logic [7:0] tw_real,
  output logic [7:0] tw_imag,
  output logic [2:0] tw_stage,
  output logic [4:0] tw_index
);

  localparam int         LOG2N  = $clog2(N);
  localparam logic [4:0] J_LAST = 5'(N / 2 - 1);
  localparam logic [2:0] S_LAST = 3'(LOG2N - 1);

  tw_state_e  state_d, state_q;
  logic [2:0] stage_d, stage_q;
  logic [4:0] index_d, index_q;
  logic       done_d, done_q;
  logic       rom_en;
  logic [7:0] rom_re, rom_im, im_sel;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    index_d = index_q;
    done_d  = 1'b0;
    rom_en  = 1'b0;
    case (state_q)
      TW_IDLE: begin
        if (start) begin
          state_d = TW_RUN;
          stage_d = '0;
          index_d = '0;
          rom_en  = 1'b1;
        end
      end
      TW_RUN: begin
        if (tw_ready) begin
          rom_en = 1'b1;
          if (index_q == J_LAST) begin
            index_d = '0;
            if (stage_q == S_LAST) begin
              state_d = TW_IDLE;
              stage_d = '0;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + 3'd1;
            end
          end else begin
            index_d = index_q + 5'd1;
          end
        end
      end
      default: state_d = TW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TW_IDLE;
      stage_q <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  // ROM is fetched with the next (s, j) so its registered word lines up with stage_q/index_q.
  fp8_twiddle_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rom_en),
    .addr  (tw_rom_addr(stage_d, index_d, LOG2N)),
    .tw_re (rom_re),
    .tw_im (rom_im)
  );

`ifdef FP8_TWIDDLE_CONJ_EN
  logic inv_d, inv_q;

  always_comb begin
    inv_d = inv_q;
    if (state_q == TW_IDLE && start) inv_d = inverse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end

  // zero keeps its sign so the conjugate never produces 8'h80
  assign im_sel = (inv_q && rom_im != FP8_ZERO) ? (rom_im ^ FP8_SIGN) : rom_im;
`else
  assign im_sel = rom_im;
`endif

  assign tw_valid = (state_q == TW_RUN);
  assign busy     = tw_valid;
  assign done     = done_q;
  assign tw_real  = tw_valid ? rom_re  : FP8_ZERO;
  assign tw_imag  = tw_valid ? im_sel  : FP8_ZERO;
  assign tw_stage = tw_valid ? stage_q : 3'd0;
  assign tw_index = tw_valid ? index_q : 5'd0;

endmodule

// File: tb/tb_fp8_twiddle_gen.sv
// Bench for fp8_twiddle_gen (N=16): stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_fp8_twiddle_gen;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic [2:0] s;
    logic [4:0] j;
  } beat_t;

  logic       clk, rst_n, start, tw_ready;
  logic       busy, done, tw_valid;
  logic [7:0] tw_real, tw_imag;
  logic [2:0] tw_stage;
  logic [4:0] tw_index;
`ifdef FP8_TWIDDLE_CONJ_EN
  logic       inverse;
`endif

  int    n_vec = 0, n_err = 0;
  int    cyc = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0, c0 = 0;
  bit    done_seen = 0, expect_done = 0, found = 0;
  beat_t q[$];

  // hand-quantized N=16 twiddles, index k = 0..7
  logic [7:0] exp_re [8] = '{8'h38, 8'h37, 8'h33, 8'h2C, 8'h00, 8'hAC, 8'hB3, 8'hB7};
  logic [7:0] exp_im [8] = '{8'h00, 8'hAC, 8'hB3, 8'hB7, 8'hB8, 8'hB7, 8'hB3, 8'hAC};

  fp8_twiddle_gen #(.N(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef FP8_TWIDDLE_CONJ_EN
    .inverse  (inverse),
`endif
    .busy     (busy),
    .done     (done),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_real  (tw_real),
    .tw_imag  (tw_imag),
    .tw_stage (tw_stage),
    .tw_index (tw_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input bit inv);
    beat_t b;
    int    k;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 8; j++) begin
        k    = (j % (1 << s)) << (3 - s);
        b.re = exp_re[k];
        b.im = exp_im[k];
        if (inv && b.im != 8'h00) b.im = b.im ^ 8'h80;
        b.s  = 3'(s);
        b.j  = 5'(j);
        q.push_back(b);
      end
    end
  endtask

  task automatic issue_start(input bit push, input bit inv);
    start = 1'b1;
`ifdef FP8_TWIDDLE_CONJ_EN
    inverse = inv;
`endif
    if (push) push_seq(inv);
    tick();
    start = 1'b0;
`ifdef FP8_TWIDDLE_CONJ_EN
    inverse = 1'b0;
`endif
  endtask

  task automatic clear_counts();
    hs_cnt    = 0;
    done_cnt  = 0;
    done_seen = 0;
  endtask

  task automatic wait_done(input int max, input string name);
    int i = 0;
    while (!done_seen && i < max) begin
      tick();
      i++;
    end
    chk({name, "_done_seen"}, 32'(done_seen), 1);
  endtask

  task automatic wait_beat(input int s, input int j, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (tw_valid && tw_stage == 3'(s) && tw_index == 5'(j)) hit = 1'b1;
      else tick();
    end
  endtask

  // Monitor: beats are judged at the negedge before the edge that consumes them.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expect_done = 1'b0;
      end else begin
        if (expect_done || done) begin
          chk("done_pulse", 32'(done), 32'(expect_done));
          if (expect_done) begin
            chk("done_cycle_valid", 32'(tw_valid), 0);
            chk("done_cycle_busy", 32'(busy), 0);
          end
        end
        if (done) begin
          done_cnt++;
          done_seen = 1'b1;
          done_cyc  = cyc;
        end
        expect_done = 1'b0;
        if (!tw_valid) begin
          chk("idle_outputs_zero", {8'h0, tw_real, tw_imag, 3'h0, tw_stage, 3'h0, tw_index}, 0);
        end else if (q.size() == 0) begin
          chk("unexpected_beat_valid", 32'(tw_valid), 0);
        end else begin
          e = q[0];
          chk("busy_in_run", 32'(busy), 1);
          chk("tw_real", 32'(tw_real), 32'(e.re));
          chk("tw_imag", 32'(tw_imag), 32'(e.im));
          chk("tw_stage", 32'(tw_stage), 32'(e.s));
          chk("tw_index", 32'(tw_index), 32'(e.j));
          if (tw_ready) begin
            void'(q.pop_front());
            hs_cnt++;
            if (q.size() == 0) expect_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected summary before it");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    tw_ready = 1'b1;
`ifdef FP8_TWIDDLE_CONJ_EN
    inverse  = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(tw_valid), 0);
    chk("rst_real", 32'(tw_real), 0);
    chk("rst_imag", 32'(tw_imag), 0);
    chk("rst_stage", 32'(tw_stage), 0);
    chk("rst_index", 32'(tw_index), 0);
    rst_n = 1'b1;
    tick();

    // full sequence, consumer always ready
    clear_counts();
    c0 = cyc;
    issue_start(1'b1, 1'b0);
    wait_done(100, "t1");
    chk("t1_start_to_done_cycles", 32'(done_cyc - c0), 33);
    chk("t1_beats", 32'(hs_cnt), 32);
    chk("t1_done_count", 32'(done_cnt), 1);

    // 5-cycle stall at s=2, j=5
    clear_counts();
    issue_start(1'b1, 1'b0);
    wait_beat(2, 5, found);
    chk("t2_reached_s2_j5", 32'(found), 1);
    tw_ready = 1'b0;
    repeat (5) tick();
    tw_ready = 1'b1;
    wait_done(100, "t2");
    chk("t2_beats", 32'(hs_cnt), 32);
    chk("t2_done_count", 32'(done_cnt), 1);

    // start during RUN is ignored
    clear_counts();
    c0 = cyc;
    issue_start(1'b1, 1'b0);
    repeat (6) tick();
    issue_start(1'b0, 1'b0);
    wait_done(100, "t3");
    repeat (5) tick();
    chk("t3_start_to_done_cycles", 32'(done_cyc - c0), 33);
    chk("t3_beats", 32'(hs_cnt), 32);
    chk("t3_done_count", 32'(done_cnt), 1);
    chk("t3_idle_after", 32'(busy), 0);

    // asynchronous reset mid-sequence
    clear_counts();
    issue_start(1'b1, 1'b0);
    wait_beat(1, 2, found);
    chk("t4_reached_s1", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_async_valid", 32'(tw_valid), 0);
    chk("t4_async_busy", 32'(busy), 0);
    chk("t4_async_outputs", {8'h0, tw_real, tw_imag, 3'h0, tw_stage, 3'h0, tw_index}, 0);
    q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
    issue_start(1'b1, 1'b0);
    wait_done(100, "t4");
    chk("t4_beats", 32'(hs_cnt), 32);
    chk("t4_done_count", 32'(done_cnt), 1);

`ifdef FP8_TWIDDLE_CONJ_EN
    // inverse twiddles: nonzero imag sign flipped for the whole sequence
    clear_counts();
    issue_start(1'b1, 1'b1);
    wait_done(100, "t5");
    chk("t5_beats", 32'(hs_cnt), 32);
    chk("t5_done_count", 32'(done_cnt), 1);
`endif

    tick();
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp8_twiddle_gen.md
FP8_TWIDDLE_GEN -- requirements
Module: fp8_twiddle_gen

Interface
REQ-001 SHALL have parameter: N, 16, FFT size; power of two, 4..64.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to emit a full twiddle sequence.
REQ-005 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-006 SHALL have port: done  output  1  one-cycle pulse after the final beat.
REQ-007 SHALL have port: tw_valid  output  1  twiddle beat available.
REQ-008 SHALL have port: tw_ready  input  1  consumer (complex-multiplier c/d operand side) accepts beat.
REQ-009 SHALL have port: tw_real  output  8  E4M3 cos(2*pi*k/N).
REQ-010 SHALL have port: tw_imag  output  8  E4M3 -sin(2*pi*k/N).
REQ-011 SHALL have port: tw_stage  output  3  butterfly stage s of current beat.
REQ-012 SHALL have port: tw_index  output  5  butterfly index j within stage.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start, RUN->IDLE after last handshake.
REQ-014 SHALL ignore start while in RUN.
REQ-015 SHALL assert tw_valid the cycle after start is sampled in IDLE; first beat s=0, j=0.
REQ-016 SHALL complete a beat only when tw_valid and tw_ready are both high on a rising edge.
REQ-017 SHALL hold tw_real, tw_imag, tw_stage, tw_index and tw_valid stable while tw_valid=1 and tw_ready=0.
REQ-018 SHALL step j 0..N/2-1 per stage, then s 0..log2(N)-1; total log2(N)*N/2 beats, one per cycle when tw_ready is held high.
REQ-019 SHALL compute exponent k = (j mod 2^s) << (log2(N)-1-s), i.e. radix-2 DIT order.
REQ-020 SHALL encode E4M3 with bias 7, round-to-nearest-even, zero as 8'h00, never negative zero.
REQ-021 SHALL produce done=1 in the cycle after the last handshake, with tw_valid=0 and busy=0 in that same cycle.
REQ-022 SHALL drive tw_real, tw_imag, tw_stage and tw_index to 0 whenever tw_valid=0.

Reset
REQ-023 SHALL on rst_n low immediately force IDLE with busy, done, tw_valid, tw_real, tw_imag, tw_stage and tw_index all 0.
REQ-024 SHALL abandon any in-flight sequence on reset; the next start restarts at s=0, j=0.

Configuration
REQ-025 SHALL, with FP8_TWIDDLE_CONJ_EN defined, add input port inverse (1 bit, sampled with start) that flips the tw_imag sign bit for nonzero tw_imag for the whole sequence (IFFT twiddles).
REQ-026 SHALL, without FP8_TWIDDLE_CONJ_EN, have no inverse port and always emit forward twiddles.

Structure
REQ-027 SHALL place E4M3 constants (FP8_ONE=8'h38, FP8_ZERO=8'h00, FP8_BIAS=7), N_MAX=64 and the 32-entry quantized W_64^k table in shared package fft_fp8_pkg.
REQ-028 SHALL implement the lookup in sub-module fp8_twiddle_rom, addressed by k*(N_MAX/N), with a registered output.

Verification
REQ-029 SHALL cover: N=16, tw_ready=1, start -> 32 beats in 32 consecutive cycles, first (0x38,0x00,s=0,j=0), done pulses once, the cycle after beat 32.
REQ-030 SHALL cover: N=16 stage 3, j=2 -> (0x33,0xB3); j=4 -> (0x00,0xB8); stage 1, j=3 -> k=4 -> (0x00,0xB8).
REQ-031 SHALL cover: tw_ready low 5 cycles at s=2, j=5 -> all outputs frozen, beat delivered once, no index skipped.
REQ-032 SHALL cover: rst_n pulsed low at s=1 -> tw_valid=0 asynchronously; later start -> first beat s=0, j=0.
REQ-033 SHALL cover: start pulsed during RUN -> beat count unchanged at 32, single done.
REQ-034 SHALL cover: FP8_TWIDDLE_CONJ_EN defined, inverse=1, N=16 k=4 -> tw_imag 0x38; k=0 -> tw_imag 0x00.
